// File: rtl/write_buffer.sv
// write_buffer: posted-write FIFO between the cache memory-side port and the RAM.
// Buffers write-backs, forwards read hits from buffered data (youngest match wins)
// and drains entries in order while the downstream port is idle.
// Optional build macro: WBUF_COALESCE_EN (a write that hits a buffered address
// overwrites that entry's data instead of allocating a new one).
`timescale 1ns/1ps
module write_buffer #(
   parameter int unsigned ADDR_WIDTH = 64,
   parameter int unsigned WORD_WIDTH = 64,
   parameter int unsigned DEPTH_BITS = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [ADDR_WIDTH-1:0] addr,
   input  logic [WORD_WIDTH-1:0] din,
   output logic [WORD_WIDTH-1:0] dout,
   input  logic                  re,
   input  logic                  we,
   output logic                  ready,
   output logic [ADDR_WIDTH-1:0] maddr,
   output logic [WORD_WIDTH-1:0] mout,
   input  logic [WORD_WIDTH-1:0] min,
   output logic                  mre,
   output logic                  mwe,
   input  logic                  mready
);
   localparam int unsigned DEPTH = 1 << DEPTH_BITS;
   localparam int unsigned CW    = DEPTH_BITS + 1;

   typedef enum logic [2:0] {UP_IDLE, UP_WR_STALL, UP_FWD, UP_RD_ISSUE, UP_RD_WAIT} up_state_e;
   typedef enum logic [1:0] {DS_IDLE, DS_SKIP, DS_BUSY} ds_state_e;

   up_state_e up_state_q;
   ds_state_e ds_state_q;

   logic [ADDR_WIDTH-1:0] addr_mem [DEPTH];
   logic [WORD_WIDTH-1:0] data_mem [DEPTH];
   logic [DEPTH_BITS-1:0] head_q, head_d, tail_q, tail_d;
   logic [CW-1:0]         count_q, count_d;
   logic [ADDR_WIDTH-1:0] req_addr_q, maddr_q;
   logic [WORD_WIDTH-1:0] req_data_q, dout_q, mout_q;
   logic                  ready_q, mre_q, mwe_q;

   logic                  accept, acc_wr, acc_rd, hit, miss_now, full;
   logic                  pop, enq, stall, coalesce, rd_issue_go;
   logic [DEPTH_BITS-1:0] hit_idx, lk_slot;
   logic [ADDR_WIDTH-1:0] enq_addr;
   logic [WORD_WIDTH-1:0] enq_data;

   assign accept      = ready_q & (re | we);
   assign acc_wr      = accept & we;
   assign acc_rd      = accept & re & ~we;
   assign miss_now    = acc_rd & ~hit;
   assign full        = (count_q == CW'(DEPTH));
   assign rd_issue_go = (up_state_q == UP_RD_ISSUE) && (ds_state_q == DS_IDLE) && mready;
   // A pending (or just-accepted) read miss takes the downstream port ahead of the drain
   assign pop         = (ds_state_q == DS_IDLE) && mready && (count_q != '0)
                        && (up_state_q != UP_RD_ISSUE) && !miss_now;
   assign stall       = acc_wr & ~coalesce & full & ~pop;
   assign enq         = (acc_wr & ~coalesce & (~full | pop))
                        | ((up_state_q == UP_WR_STALL) & pop);
   assign enq_addr    = (up_state_q == UP_WR_STALL) ? req_addr_q : addr;
   assign enq_data    = (up_state_q == UP_WR_STALL) ? req_data_q : din;

   // Read-hit lookup over valid entries only, scanned oldest to youngest
   always_comb begin
      hit     = 1'b0;
      hit_idx = '0;
      lk_slot = '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
         lk_slot = head_q + DEPTH_BITS'(i);
         if ((CW'(i) < count_q) && (addr_mem[lk_slot] == addr)) begin
            hit     = 1'b1;
            hit_idx = lk_slot;
         end
      end
   end

`ifdef WBUF_COALESCE_EN
   logic                  wmatch;
   logic [DEPTH_BITS-1:0] wmatch_idx, wm_slot;

   // Write-coalesce lookup; the head being popped this edge is not a candidate
   always_comb begin
      wmatch     = 1'b0;
      wmatch_idx = '0;
      wm_slot    = '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
         wm_slot = head_q + DEPTH_BITS'(i);
         if ((CW'(i) < count_q) && !(pop && (i == 0)) && (addr_mem[wm_slot] == addr)) begin
            wmatch     = 1'b1;
            wmatch_idx = wm_slot;
         end
      end
   end

   assign coalesce = acc_wr & wmatch;
`else
   assign coalesce = 1'b0;
`endif

   // Pointer and occupancy next-state
   always_comb begin
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q + CW'(enq) - CW'(pop);
      if (pop) head_d = head_q + DEPTH_BITS'(1);
      if (enq) tail_d = tail_q + DEPTH_BITS'(1);
   end

   // Entry storage; validity is tracked by head/count so no reset is needed
   always_ff @(posedge clk) begin
      if (enq) begin
         addr_mem[tail_q] <= enq_addr;
         data_mem[tail_q] <= enq_data;
      end
`ifdef WBUF_COALESCE_EN
      if (coalesce) data_mem[wmatch_idx] <= din;
`endif
   end

   // Upstream and downstream FSMs, FIFO pointers and registered outputs
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         up_state_q <= UP_IDLE;
         ds_state_q <= DS_IDLE;
         head_q     <= '0;
         tail_q     <= '0;
         count_q    <= '0;
         req_addr_q <= '0;
         req_data_q <= '0;
         ready_q    <= 1'b0;
         dout_q     <= '0;
         maddr_q    <= '0;
         mout_q     <= '0;
         mre_q      <= 1'b0;
         mwe_q      <= 1'b0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
         mre_q   <= 1'b0;
         mwe_q   <= 1'b0;

         if (pop) begin
            mwe_q   <= 1'b1;
            maddr_q <= addr_mem[head_q];
            mout_q  <= data_mem[head_q];
         end

         case (ds_state_q)
            DS_IDLE: if (pop || rd_issue_go) ds_state_q <= DS_SKIP;
            DS_SKIP: ds_state_q <= DS_BUSY;
            DS_BUSY: if (mready) ds_state_q <= DS_IDLE;
            default: ds_state_q <= DS_IDLE;
         endcase

         case (up_state_q)
            UP_IDLE: begin
               ready_q <= 1'b1;
               if (accept) begin
                  ready_q <= 1'b0;
                  if (acc_wr) begin
                     if (stall) begin
                        up_state_q <= UP_WR_STALL;
                        req_addr_q <= addr;
                        req_data_q <= din;
                     end
                  end else if (hit) begin
                     dout_q     <= data_mem[hit_idx];
                     up_state_q <= UP_FWD;
                  end else begin
                     req_addr_q <= addr;
                     up_state_q <= UP_RD_ISSUE;
                  end
               end
            end
            UP_WR_STALL: begin
               if (pop) begin
                  up_state_q <= UP_IDLE;
                  ready_q    <= 1'b1;
               end
            end
            UP_FWD: begin
               up_state_q <= UP_IDLE;
               ready_q    <= 1'b1;
            end
            UP_RD_ISSUE: begin
               if (rd_issue_go) begin
                  mre_q      <= 1'b1;
                  maddr_q    <= req_addr_q;
                  up_state_q <= UP_RD_WAIT;
               end
            end
            UP_RD_WAIT: begin
               if ((ds_state_q == DS_BUSY) && mready) begin
                  dout_q     <= min;
                  up_state_q <= UP_IDLE;
                  ready_q    <= 1'b1;
               end
            end
            default: up_state_q <= UP_IDLE;
         endcase
      end
   end

   assign dout  = dout_q;
   assign ready = ready_q;
   assign maddr = maddr_q;
   assign mout  = mout_q;
   assign mre   = mre_q;
   assign mwe   = mwe_q;
endmodule

// File: tb/tb_write_buffer.sv
// Directed self-checking bench for write_buffer.
`timescale 1ns/1ps
module tb_write_buffer;
   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [63:0] addr = '0, din = '0, min = '0;
   logic [63:0] dout, maddr, mout;
   logic        re = 1'b0, we = 1'b0, mready = 1'b1;
   logic        ready, mre, mwe;

   int errors = 0;
   int checks = 0;

   write_buffer dut (
      .clk(clk), .rst(rst), .addr(addr), .din(din), .dout(dout),
      .re(re), .we(we), .ready(ready), .maddr(maddr), .mout(mout),
      .min(min), .mre(mre), .mwe(mwe), .mready(mready)
   );

   always #5 clk = ~clk;

   // Downstream observer: logs RAM writes, counts reads, flags pulse overlap/back-to-back
   logic [63:0] log_a[$];
   logic [63:0] log_d[$];
   int   mre_cnt = 0;
   int   viol = 0;
   logic prev_pulse = 1'b0;
   always @(negedge clk) begin
      if (mwe === 1'b1) begin
         log_a.push_back(maddr);
         log_d.push_back(mout);
      end
      if (mre === 1'b1) mre_cnt++;
      if (mre === 1'b1 && mwe === 1'b1) viol++;
      if ((mre === 1'b1 || mwe === 1'b1) && prev_pulse) viol++;
      prev_pulse = (mre === 1'b1) || (mwe === 1'b1);
   end

   // Issue one write pulse once ready is seen; returns at the negedge after the accept edge
   task automatic do_write(input logic [63:0] a, input logic [63:0] d, output bit ok);
      int n;
      n = 0;
      while (ready !== 1'b1 && n < 50) begin
         @(negedge clk);
         n++;
      end
      ok   = (ready === 1'b1);
      we   = 1'b1;
      addr = a;
      din  = d;
      @(negedge clk);
      we   = 1'b0;
   endtask

   task automatic wait_log(input int target);
      int n;
      n = 0;
      while (log_a.size() < target && n < 80) begin
         @(negedge clk);
         n++;
      end
   endtask

   task automatic test_reset();
      rst = 1'b0;
      mready = 1'b1;
      @(negedge clk);
      checks++; if (ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b want 0", ready); end
      checks++; if (dout !== 64'd0) begin errors++; $display("FAIL reset_dout: got %h want 0", dout); end
      checks++; if ({maddr, mout} !== 128'd0) begin errors++; $display("FAIL reset_mbus: got %h/%h want 0/0", maddr, mout); end
      checks++; if ({mre, mwe} !== 2'b00) begin errors++; $display("FAIL reset_pulses: got %b want 00", {mre, mwe}); end
      rst = 1'b1;
      @(negedge clk);
      checks++; if (ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready: got %b want 1", ready); end
      checks++; if (dut.count_q !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", dut.count_q); end
   endtask

   task automatic test_single_write();
      bit ok;
      int base;
      base = log_a.size();
      do_write(64'd1, 64'h0123456789abcdef, ok);
      checks++; if (!ok) begin errors++; $display("FAIL sw_accept: ready never high"); end
      checks++; if (ready !== 1'b0) begin errors++; $display("FAIL sw_ready_low: got %b want 0", ready); end
      @(negedge clk);
      checks++; if (ready !== 1'b1) begin errors++; $display("FAIL sw_ready_back: got %b want 1", ready); end
      checks++; if (mwe !== 1'b1 || maddr !== 64'd1 || mout !== 64'h0123456789abcdef) begin
         errors++; $display("FAIL sw_drain: got mwe=%b maddr=%h mout=%h want 1/1/0123456789abcdef", mwe, maddr, mout);
      end
      repeat (4) @(negedge clk);
      checks++; if (log_a.size() !== base + 1) begin errors++; $display("FAIL sw_log_size: got %0d want %0d", log_a.size(), base + 1); end
   endtask

   task automatic test_fill_stall();
      bit ok, all_ok, low;
      int base;
      base   = log_a.size();
      mready = 1'b0;
      all_ok = 1'b1;
      for (int i = 0; i < 4; i++) begin
         do_write(64'h10 + 64'(i), 64'h1000 + 64'(i), ok);
         if (!ok) all_ok = 1'b0;
      end
      checks++; if (!all_ok) begin errors++; $display("FAIL fill_accept: a write was not accepted"); end
      checks++; if (dut.count_q !== 3'd4) begin errors++; $display("FAIL fill_count: got %0d want 4", dut.count_q); end
      @(negedge clk);
      we = 1'b1; addr = 64'h14; din = 64'h1004;
      @(negedge clk);
      we = 1'b0;
      low = 1'b1;
      repeat (4) begin
         if (ready !== 1'b0) low = 1'b0;
         @(negedge clk);
      end
      checks++; if (!low) begin errors++; $display("FAIL stall_ready: ready rose while full, want 0"); end
      checks++; if (log_a.size() !== base) begin errors++; $display("FAIL stall_no_drain: got %0d writes want 0", log_a.size() - base); end
      mready = 1'b1;
      @(negedge clk);
      checks++; if (ready !== 1'b1 || mwe !== 1'b1 || maddr !== 64'h10) begin
         errors++; $display("FAIL stall_release: got ready=%b mwe=%b maddr=%h want 1/1/10", ready, mwe, maddr);
      end
      checks++; if (dut.count_q !== 3'd4) begin errors++; $display("FAIL stall_count: got %0d want 4", dut.count_q); end
      wait_log(base + 5);
      checks++; if (log_a.size() !== base + 5) begin errors++; $display("FAIL fill_log_size: got %0d want %0d", log_a.size(), base + 5); end
      for (int i = 0; i < 5; i++) begin
         if (log_a.size() > base + i) begin
            checks++;
            if (log_a[base + i] !== 64'h10 + 64'(i) || log_d[base + i] !== 64'h1000 + 64'(i)) begin
               errors++; $display("FAIL fill_order[%0d]: got %h/%h want %h/%h", i, log_a[base + i], log_d[base + i],
                                  64'h10 + 64'(i), 64'h1000 + 64'(i));
            end
         end
      end
      repeat (4) @(negedge clk);
      mready = 1'b0;
   endtask

   task automatic test_read_hit();
      bit ok;
      int mb;
      mb = mre_cnt;
      do_write(64'd257, 64'd123, ok);
      checks++; if (!ok) begin errors++; $display("FAIL hit_wr_accept: ready never high"); end
      @(negedge clk);
      re = 1'b1; addr = 64'd257;
      @(negedge clk);
      re = 1'b0;
      checks++; if (ready !== 1'b0) begin errors++; $display("FAIL hit_ready_low: got %b want 0", ready); end
      @(negedge clk);
      checks++; if (ready !== 1'b1 || dout !== 64'd123) begin
         errors++; $display("FAIL hit_fwd: got ready=%b dout=%0d want 1/123", ready, dout);
      end
      checks++; if (mre_cnt !== mb) begin errors++; $display("FAIL hit_no_mre: got %0d reads want 0", mre_cnt - mb); end
   endtask

   task automatic test_youngest();
      bit ok1, ok2;
      int base, n_exp;
      base = log_a.size();
      do_write(64'd256, 64'd5, ok1);
      do_write(64'd256, 64'd9, ok2);
      checks++; if (!(ok1 && ok2)) begin errors++; $display("FAIL young_accept: a write was not accepted"); end
      @(negedge clk);
      re = 1'b1; addr = 64'd256;
      @(negedge clk);
      re = 1'b0;
      @(negedge clk);
      checks++; if (ready !== 1'b1 || dout !== 64'd9) begin
         errors++; $display("FAIL young_fwd: got ready=%b dout=%0d want 1/9", ready, dout);
      end
`ifdef WBUF_COALESCE_EN
      n_exp = 2;
`else
      n_exp = 3;
`endif
      checks++; if (dut.count_q !== 3'(n_exp)) begin errors++; $display("FAIL young_count: got %0d want %0d", dut.count_q, n_exp); end
      mready = 1'b1;
      wait_log(base + n_exp);
      repeat (4) @(negedge clk);
      checks++; if (log_a.size() !== base + n_exp) begin errors++; $display("FAIL young_log_size: got %0d want %0d", log_a.size() - base, n_exp); end
      if (log_a.size() == base + n_exp) begin
         checks++; if (log_a[base] !== 64'd257 || log_d[base] !== 64'd123) begin
            errors++; $display("FAIL young_drain0: got %0d/%0d want 257/123", log_a[base], log_d[base]);
         end
`ifdef WBUF_COALESCE_EN
         checks++; if (log_a[base + 1] !== 64'd256 || log_d[base + 1] !== 64'd9) begin
            errors++; $display("FAIL young_drain1: got %0d/%0d want 256/9", log_a[base + 1], log_d[base + 1]);
         end
`else
         checks++; if (log_a[base + 1] !== 64'd256 || log_d[base + 1] !== 64'd5) begin
            errors++; $display("FAIL young_drain1: got %0d/%0d want 256/5", log_a[base + 1], log_d[base + 1]);
         end
         checks++; if (log_a[base + 2] !== 64'd256 || log_d[base + 2] !== 64'd9) begin
            errors++; $display("FAIL young_drain2: got %0d/%0d want 256/9", log_a[base + 2], log_d[base + 2]);
         end
`endif
      end
      mready = 1'b0;
   endtask

   task automatic test_read_miss();
      bit ok;
      int base, n;
      base = log_a.size();
      min  = '1;
      do_write(64'h20, 64'h2020, ok);
      checks++; if (!ok) begin errors++; $display("FAIL miss_wr_accept: ready never high"); end
      @(negedge clk);
      re = 1'b1; addr = 64'h30;
      @(negedge clk);
      re = 1'b0;
      checks++; if (ready !== 1'b0) begin errors++; $display("FAIL miss_ready_low: got %b want 0", ready); end
      mready = 1'b1;
      @(negedge clk);
      checks++; if (mre !== 1'b1 || mwe !== 1'b0 || maddr !== 64'h30) begin
         errors++; $display("FAIL miss_mre: got mre=%b mwe=%b maddr=%h want 1/0/30", mre, mwe, maddr);
      end
      checks++; if (log_a.size() !== base) begin errors++; $display("FAIL miss_before_drain: got %0d writes want 0", log_a.size() - base); end
      n = 0;
      while (ready !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      checks++; if (ready !== 1'b1 || dout !== 64'hffffffffffffffff) begin
         errors++; $display("FAIL miss_dout: got ready=%b dout=%h want 1/ffffffffffffffff", ready, dout);
      end
      wait_log(base + 1);
      checks++; if (log_a.size() !== base + 1 || log_a[base] !== 64'h20 || log_d[base] !== 64'h2020) begin
         errors++; $display("FAIL miss_then_drain: got %0d writes, first %h want 1 write of 20/2020",
                            log_a.size() - base, (log_a.size() > base) ? log_a[base] : 64'h0);
      end
      repeat (4) @(negedge clk);
      mready = 1'b0;
   endtask

   task automatic test_reset_mid_drain();
      bit ok, all_ok;
      int base;
      base   = log_a.size();
      all_ok = 1'b1;
      for (int i = 0; i < 3; i++) begin
         do_write(64'h40 + 64'(i), 64'h4000 + 64'(i), ok);
         if (!ok) all_ok = 1'b0;
      end
      checks++; if (!all_ok || dut.count_q !== 3'd3) begin
         errors++; $display("FAIL rst_fill: got accept=%b count=%0d want 1/3", all_ok, dut.count_q);
      end
      mready = 1'b1;
      @(negedge clk);
      checks++; if (mwe !== 1'b1 || maddr !== 64'h40) begin errors++; $display("FAIL rst_drain_start: got mwe=%b maddr=%h want 1/40", mwe, maddr); end
      #2 rst = 1'b0;
      #1;
      checks++; if ({ready, mre, mwe} !== 3'b000) begin errors++; $display("FAIL rst_async_ctl: got %b want 000", {ready, mre, mwe}); end
      checks++; if ({dout, maddr, mout} !== 192'd0) begin errors++; $display("FAIL rst_async_data: got %h/%h/%h want 0", dout, maddr, mout); end
      checks++; if (dut.count_q !== 3'd0) begin errors++; $display("FAIL rst_async_count: got %0d want 0", dut.count_q); end
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      repeat (12) @(negedge clk);
      checks++; if (log_a.size() !== base + 1) begin errors++; $display("FAIL rst_no_more_mwe: got %0d writes want 1", log_a.size() - base); end
      checks++; if (ready !== 1'b1) begin errors++; $display("FAIL rst_ready_after: got %b want 1", ready); end
   endtask

   task automatic test_protocol();
      checks++; if (viol !== 0) begin errors++; $display("FAIL pulse_rules: got %0d violations want 0", viol); end
      checks++; if (mre_cnt !== 1) begin errors++; $display("FAIL mre_total: got %0d want 1", mre_cnt); end
   endtask

   initial begin
      test_reset();
      test_single_write();
      test_fill_stall();
      test_read_hit();
      test_youngest();
      test_read_miss();
      test_reset_mid_drain();
      test_protocol();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end
endmodule
